sipo_receiver: RTL and testbench

- Serial-to-parallel receiver: the receiving end of the library's mux/ffd-based serial transmit path.
- Samples one bit per enabled clock from a framed serial line and assembles WIDTH-bit words.
- Presents each completed word with a single-cycle valid strobe.
- Sits between the serial link and any parallel consumer in the library-level designs.

---
 rtl/sipo_receiver.sv | 103 ++++++++++
 tb/tb_sipo_receiver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_receiver.sv
// Serial-to-parallel word receiver; optional even-parity bit via SIPO_PARITY_CHECK_EN.
// Latency: oValid/oData update on the edge that samples the last bit of a frame.
// Backpressure: none; iEnb (active-low) freezes the receiver in place.
module sipo_receiver #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             iClk,
  input  logic             iClr,
  input  logic             iEnb,
  input  logic             iSerial,
  input  logic             iFrame,
  output logic [WIDTH-1:0] oData,
  output logic             oValid,
  output logic             oBusy,
  output logic             oErr,
  output logic             oParErr
);

`ifdef SIPO_PARITY_CHECK_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif
  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_BITS - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t           state;
  logic [CW-1:0]    bitCnt;
  logic [WIDTH-1:0] shiftReg;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] firstWord;

  // firstWord starts a fresh word so stale bits never leak into the next one.
  always_comb begin
    if (MSB_FIRST) begin
      shifted   = (shiftReg << 1) | WIDTH'(iSerial);
      firstWord = WIDTH'(iSerial);
    end else begin
      shifted   = (shiftReg >> 1) | (WIDTH'(iSerial) << (WIDTH - 1));
      firstWord = WIDTH'(iSerial) << (WIDTH - 1);
    end
  end

  always_ff @(posedge iClk or posedge iClr) begin
    if (iClr) begin
      state    <= IDLE;
      bitCnt   <= '0;
      shiftReg <= '0;
      oData    <= '0;
      oValid   <= 1'b0;
      oBusy    <= 1'b0;
      oErr     <= 1'b0;
      oParErr  <= 1'b0;
    end else begin
      oValid  <= 1'b0;
      oErr    <= 1'b0;
      oParErr <= 1'b0;
      if (!iEnb) begin
        unique case (state)
          IDLE: begin
            if (iFrame) begin
              shiftReg <= firstWord;
              bitCnt   <= CW'(1);
              state    <= RECV;
              oBusy    <= 1'b1;
            end
          end
          RECV: begin
            if (iFrame) begin
              // Framing error: drop the partial word, this bit opens a new one.
              oErr     <= 1'b1;
              shiftReg <= firstWord;
              bitCnt   <= CW'(1);
            end else if (bitCnt == LAST_IDX) begin
`ifdef SIPO_PARITY_CHECK_EN
              oData    <= shiftReg;
              oParErr  <= ^{shiftReg, iSerial};
`else
              oData    <= shifted;
              shiftReg <= shifted;
`endif
              oValid   <= 1'b1;
              bitCnt   <= '0;
              state    <= IDLE;
              oBusy    <= 1'b0;
            end else begin
              shiftReg <= shifted;
              bitCnt   <= bitCnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            oBusy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sipo_receiver.sv
// Bench for sipo_receiver: directed table, hand-written corner sequences and a
// randomized run, all compared against a bit-list model of the framing rules.
module tb_sipo_receiver;
  localparam int W = 8;
`ifdef SIPO_PARITY_CHECK_EN
  localparam int NB  = W + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = W;
  localparam bit PAR = 1'b0;
`endif

  logic iClk = 1'b0;
  logic iClr, iEnb, iSerial, iFrame;
  logic [W-1:0] dataM, dataL;
  logic validM, busyM, errM, parM;
  logic validL, busyL, errL, parL;

  sipo_receiver #(.WIDTH(W), .MSB_FIRST(1'b1)) dutM (
    .iClk(iClk), .iClr(iClr), .iEnb(iEnb), .iSerial(iSerial), .iFrame(iFrame),
    .oData(dataM), .oValid(validM), .oBusy(busyM), .oErr(errM), .oParErr(parM)
  );
  sipo_receiver #(.WIDTH(W), .MSB_FIRST(1'b0)) dutL (
    .iClk(iClk), .iClr(iClr), .iEnb(iEnb), .iSerial(iSerial), .iFrame(iFrame),
    .oData(dataL), .oValid(validL), .oBusy(busyL), .oErr(errL), .oParErr(parL)
  );

  always #5 iClk = ~iClk;

  int nVec  = 0;
  int nFail = 0;

  // Model: the bits of the word in flight, in arrival order.
  bit           bitsQ[$];
  logic [W-1:0] mDataM = '0;
  logic [W-1:0] mDataL = '0;
  logic         mValid = 1'b0;
  logic         mErr   = 1'b0;
  logic         mPar   = 1'b0;
  logic         firstErr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelStep(input bit clr, input bit enb, input bit ser, input bit frm);
    logic [W-1:0] m;
    logic [W-1:0] l;
    bit           p;
    mValid = 1'b0;
    mErr   = 1'b0;
    mPar   = 1'b0;
    if (clr) begin
      bitsQ.delete();
      mDataM = '0;
      mDataL = '0;
      return;
    end
    if (enb) return;
    if (frm) begin
      if (bitsQ.size() != 0) mErr = 1'b1;
      bitsQ.delete();
      bitsQ.push_back(ser);
    end else if (bitsQ.size() != 0) begin
      bitsQ.push_back(ser);
    end
    if (bitsQ.size() == NB) begin
      m = '0;
      l = '0;
      p = 1'b0;
      for (int i = 0; i < W; i++) begin
        m[W-1-i] = bitsQ[i];
        l[i]     = bitsQ[i];
      end
      for (int i = 0; i < NB; i++) p ^= bitsQ[i];
      mValid = 1'b1;
      mDataM = m;
      mDataL = l;
      if (PAR) mPar = p;
      bitsQ.delete();
    end
  endfunction

  task automatic compareAll();
    logic expBusy;
    expBusy = (bitsQ.size() != 0);
    chk("validM", validM, mValid);
    chk("errM",   errM,   mErr);
    chk("parM",   parM,   mPar);
    chk("busyM",  busyM,  expBusy);
    chk("dataM",  dataM,  mDataM);
    chk("validL", validL, mValid);
    chk("errL",   errL,   mErr);
    chk("parL",   parL,   mPar);
    chk("busyL",  busyL,  expBusy);
    chk("dataL",  dataL,  mDataL);
  endtask

  task automatic step(input bit clr, input bit enb, input bit ser, input bit frm);
    iClr    = clr;
    iEnb    = enb;
    iSerial = ser;
    iFrame  = frm;
    @(posedge iClk);
    #1;
    modelStep(clr, enb, ser, frm);
    compareAll();
  endtask

  // Sends one framed word (plus parity bit when enabled); optional 3-cycle freeze.
  task automatic sendWord(input logic [W-1:0] v, input bit msbOrder, input int freezeAt,
                          input bit badPar);
    bit b;
    for (int i = 0; i < W; i++) begin
      if (i == freezeAt) begin
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'($urandom), 1'b1);
      end
      b = msbOrder ? v[W-1-i] : v[i];
      step(1'b0, 1'b0, b, i == 0);
      if (i == 0) firstErr = errM;
    end
    if (PAR) step(1'b0, 1'b0, (^v) ^ badPar, 1'b0);
  endtask

  typedef struct {
    bit           frm;
    bit           ser;
    bit           expBusy;
    bit           expValid;
    logic [W-1:0] expData;
  } vec_t;

  vec_t         tbl[9];
  logic [W-1:0] a5;

  initial begin
    a5 = 8'hA5;
    for (int i = 0; i < 8; i++)
      tbl[i] = '{frm: (i == 0), ser: a5[7-i], expBusy: (i < 7) || PAR,
                 expValid: (i == 7) && !PAR, expData: ((i == 7) && !PAR) ? a5 : 8'h00};
    tbl[8] = '{frm: 1'b0, ser: ^a5, expBusy: 1'b0, expValid: PAR, expData: a5};

    // Reset state
    iClr = 1'b1; iEnb = 1'b0; iSerial = 1'b0; iFrame = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rstData", dataM, 0);
    chk("rstBusy", busyM, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // 0xA5 table (palindrome: both bit orders give 0xA5)
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b0, tbl[i].ser, tbl[i].frm);
      chk($sformatf("tblBusy%0d", i),  busyM,  tbl[i].expBusy);
      chk($sformatf("tblValid%0d", i), validM, tbl[i].expValid);
      chk($sformatf("tblDataM%0d", i), dataM,  tbl[i].expData);
      chk($sformatf("tblDataL%0d", i), dataL,  tbl[i].expData);
    end

    // 0x01 sent LSB-first
    sendWord(8'h01, 1'b0, -1, 1'b0);
    chk("lsbValid", validL, 1);
    chk("lsbDataL", dataL, 8'h01);
    chk("lsbDataM", dataM, 8'h80);

    // Back-to-back words with zero gap
    sendWord(8'h3C, 1'b1, -1, 1'b0);
    chk("b2bData0", dataM, 8'h3C);
    sendWord(8'hC3, 1'b1, -1, 1'b0);
    chk("b2bValid1", validM, 1);
    chk("b2bData1", dataM, 8'hC3);

    // Frame reasserted at bit 5
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    sendWord(8'hFF, 1'b1, -1, 1'b0);
    chk("frmErr", firstErr, 1);
    chk("frmData", dataM, 8'hFF);

    // Freeze mid-word
    sendWord(8'h96, 1'b1, 4, 1'b0);
    chk("frzValid", validM, 1);
    chk("frzData", dataM, 8'h96);

    // Async clear mid-word
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    iClr = 1'b1;
    #2;
    chk("clrData", dataM, 0);
    chk("clrBusy", busyM, 0);
    chk("clrValid", validM, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    sendWord(8'h5A, 1'b1, -1, 1'b0);
    chk("clrNext", dataM, 8'h5A);

    if (PAR) begin
      sendWord(8'h07, 1'b1, -1, 1'b0);
      chk("parOkValid", validM, 1);
      chk("parOk", parM, 0);
      sendWord(8'h07, 1'b1, -1, 1'b1);
      chk("parBadValid", validM, 1);
      chk("parBad", parM, 1);
      chk("parBadData", dataM, 8'h07);
    end

    // Randomized run
    for (int n = 0; n < 1500; n++) begin
      bit clr, enb, frm;
      clr = ($urandom_range(0, 199) == 0);
      enb = ($urandom_range(0, 4) == 0);
      frm = (bitsQ.size() == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 11) == 0);
      step(clr, enb, 1'($urandom), frm);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
